nibble_mult8_seq: RTL



---
 rtl/mult_pkg.sv | 25 ++
 rtl/nibble_mult8_seq_wallace.sv | 24 ++
 rtl/nibble_mult8_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the nibble-serial 8x8 multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned ACC_W  = 20;

  // Left shift applied to the tree product for each nibble-pair step.
  function automatic logic [3:0] shift_for(input logic [1:0] cnt);
    case (cnt)
      2'd0:    shift_for = 4'd0;
      2'd1:    shift_for = 4'd4;
      2'd2:    shift_for = 4'd4;
      default: shift_for = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/nibble_mult8_seq_wallace.sv
// Existing combinational 4x4 unsigned multiplier (Wallace tree reduction).
module WallaceTree4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] prod
);

  logic [7:0] pp0, pp1, pp2, pp3;
  logic [7:0] s1, c1, s2, c2;

  assign pp0 = {4'b0, A & {4{B[0]}}};
  assign pp1 = {3'b0, A & {4{B[1]}}, 1'b0};
  assign pp2 = {2'b0, A & {4{B[2]}}, 2'b0};
  assign pp3 = {1'b0, A & {4{B[3]}}, 3'b0};

  // Two carry-save layers reduce four rows to two before the final add.
  assign s1 = pp0 ^ pp1 ^ pp2;
  assign c1 = {((pp0[6:0] & pp1[6:0]) | (pp0[6:0] & pp2[6:0]) | (pp1[6:0] & pp2[6:0])), 1'b0};
  assign s2 = s1 ^ c1 ^ pp3;
  assign c2 = {((s1[6:0] & c1[6:0]) | (s1[6:0] & pp3[6:0]) | (c1[6:0] & pp3[6:0])), 1'b0};

  assign prod = s2 + c2;

endmodule

// File: rtl/nibble_mult8_seq.sv
// Sequential 8x8 multiplier: four nibble products through one 4x4 tree,
// valid/ready on both sides. Define NIBBLE_MULT8_SIGNED_EN for two's complement.
module nibble_mult8_seq
  import mult_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_a,
  input  logic [OP_W-1:0]     in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   out_prod,
  output logic                busy
);

  state_t              state;
  logic [1:0]          cnt;
  logic [OP_W-1:0]     op_a, op_b;
  logic [ACC_W-1:0]    acc, sum;
  logic [NIB_W-1:0]    tree_a, tree_b;
  logic [2*NIB_W-1:0]  tree_prod;
  logic [PROD_W-1:0]   result;

  WallaceTree4bit u_tree (
    .A    (tree_a),
    .B    (tree_b),
    .prod (tree_prod)
  );

  assign in_ready = (state == IDLE);

  // Tree inputs stay at zero outside CALC so the tree is quiet when idle.
  always_comb begin
    tree_a = '0;
    tree_b = '0;
    if (state == CALC) begin
      tree_a = cnt[1] ? op_a[7:4] : op_a[3:0];
      tree_b = cnt[0] ? op_b[7:4] : op_b[3:0];
    end
  end

  assign sum = acc + (ACC_W'(tree_prod) << shift_for(cnt));

`ifdef NIBBLE_MULT8_SIGNED_EN
  logic neg;

  function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] v);
    mag = v[OP_W-1] ? OP_W'(-v) : v;
  endfunction

  assign result = neg ? PROD_W'(-sum[PROD_W-1:0]) : sum[PROD_W-1:0];
`else
  assign result = sum[PROD_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      out_prod  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef NIBBLE_MULT8_SIGNED_EN
      neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef NIBBLE_MULT8_SIGNED_EN
            op_a <= mag(in_a);
            op_b <= mag(in_b);
            neg  <= in_a[OP_W-1] ^ in_b[OP_W-1];
`else
            op_a <= in_a;
            op_b <= in_b;
`endif
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= sum;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            out_prod  <= result;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
